// File: rtl/act_pkg.sv
// Shared constants and encodings for the tanh/sigmoid activation stage.
// Data format is Q3.12 signed; the divider produces ITER quotient bits.
package act_pkg;

  localparam int unsigned FRAC = 12;
  localparam int unsigned ONE  = 1 << FRAC;
  localparam int unsigned ITER = FRAC + 2;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StDone
  } act_state_e;

  localparam logic ACT_TANH    = 1'b0;
  localparam logic ACT_SIGMOID = 1'b1;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// The partial remainder is preloaded with the upper dividend bits; o_ovf flags a quotient >= 2^ITER.
module seq_divider #(
  parameter int unsigned RW   = 17,
  parameter int unsigned ITER = 14
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic [RW-1:0]   i_rem_init,
  input  logic [ITER-1:0] i_dividend,
  input  logic [RW-1:0]   i_divisor,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_ovf,
  output logic [ITER-1:0] o_quot
);

  localparam int unsigned CW = $clog2(ITER);

  logic [RW-1:0]   r_rem;
  logic [RW-1:0]   r_div;
  logic [ITER-1:0] r_dvd;
  logic [ITER-1:0] r_quot;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_ovf;

  logic [RW-1:0]   w_shift;
  logic [RW-1:0]   w_rem_nxt;
  logic            w_ge;

  always_comb begin
    w_shift   = RW'({r_rem, r_dvd[ITER-1]});
    w_ge      = (w_shift >= r_div);
    w_rem_nxt = w_ge ? (w_shift - r_div) : w_shift;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem  <= '0;
      r_div  <= '0;
      r_dvd  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (i_start) begin
      r_rem  <= i_rem_init;
      r_div  <= i_divisor;
      r_dvd  <= i_dividend;
      r_quot <= '0;
      r_cnt  <= CW'(ITER - 1);
      r_busy <= 1'b1;
      r_done <= 1'b0;
      // Preloaded remainder already >= divisor means the quotient cannot fit in ITER bits.
      r_ovf  <= (i_rem_init >= i_divisor);
    end else if (r_busy) begin
      r_rem  <= w_rem_nxt;
      r_dvd  <= r_dvd << 1;
      r_quot <= {r_quot[ITER-2:0], w_ge};
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_ovf  = r_ovf;
  assign o_quot = r_quot;

endmodule

// File: rtl/act_tanh_div.sv
// Activation stage: tanh = sinh/cosh (or sigmoid = (1+tanh)/2) via a sequential divider,
// with a valid/ready handshake on both sides.
module act_tanh_div
  import act_pkg::*;
#(
  parameter int unsigned WIDTH = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:0] Sin_H,
  input  logic [WIDTH:0] Cos_H,
  input  logic           act_sel,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:0] act_out,
  output logic           div_err
);

  localparam int unsigned RW  = WIDTH + 2;
  localparam int unsigned PRE = ITER - FRAC;

  act_state_e r_state;
  logic       r_in_ready;
  logic       r_out_valid;
  logic [WIDTH:0] r_act_out;
  logic       r_div_err;
  logic       r_sign;
  logic       r_sel;

  logic [RW-1:0]   w_sin_ext;
  logic [RW-1:0]   w_sin_abs;
  logic [RW-1:0]   w_rem_init;
  logic [RW-1:0]   w_divisor;
  logic [ITER-1:0] w_dvd_lo;
  logic [ITER-1:0] w_quot;
  logic            w_cos_pos;
  logic            w_accept;
  logic            w_start;
  logic            w_div_busy;
  logic            w_div_done;
  logic            w_div_ovf;
  logic signed [RW-1:0] w_mag;
  logic signed [RW-1:0] w_t;
  logic signed [RW-1:0] w_sum;
  logic signed [RW-1:0] w_sig;
  logic [WIDTH:0]  w_act;

  always_comb begin
    // Magnitude in one extra bit so -32768 maps to +32768.
    w_sin_ext  = {Sin_H[WIDTH], Sin_H};
    w_sin_abs  = Sin_H[WIDTH] ? (~w_sin_ext + RW'(1)) : w_sin_ext;
    w_cos_pos  = ~Cos_H[WIDTH] & (|Cos_H);
    w_rem_init = w_sin_abs >> PRE;
    w_dvd_lo   = {w_sin_abs[PRE-1:0], {FRAC{1'b0}}};
    w_divisor  = {1'b0, Cos_H};
    w_accept   = r_in_ready & in_valid & ~w_div_busy;
    w_start    = w_accept & w_cos_pos;
  end

  seq_divider #(
    .RW   (RW),
    .ITER (ITER)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_start),
    .i_rem_init (w_rem_init),
    .i_dividend (w_dvd_lo),
    .i_divisor  (w_divisor),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_ovf      (w_div_ovf),
    .o_quot     (w_quot)
  );

  // Saturate |tanh| to 1.0, restore sign, optionally rescale to sigmoid in [0, ONE].
  always_comb begin
    w_mag = (w_div_ovf || (w_quot > ITER'(ONE))) ? RW'(ONE) : RW'(w_quot);
    w_t   = r_sign ? -w_mag : w_mag;
    w_sum = RW'(ONE) + w_t;
    w_sig = w_sum >>> 1;
    w_act = (r_sel == ACT_SIGMOID) ? (WIDTH + 1)'(w_sig) : (WIDTH + 1)'(w_t);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_act_out   <= '0;
      r_div_err   <= 1'b0;
      r_sign      <= 1'b0;
      r_sel       <= ACT_TANH;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_sign     <= Sin_H[WIDTH];
            r_sel      <= act_sel;
            r_in_ready <= 1'b0;
            if (w_cos_pos) begin
              r_state <= StDiv;
            end else begin
              r_state     <= StDone;
              r_out_valid <= 1'b1;
              r_act_out   <= '0;
              r_div_err   <= 1'b1;
            end
          end
        end
        StDiv: begin
          if (w_div_done) begin
            r_state     <= StDone;
            r_out_valid <= 1'b1;
            r_act_out   <= w_act;
            r_div_err   <= 1'b0;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign act_out   = r_act_out;
  assign div_err   = r_div_err;

endmodule
